// File: rtl/m_control_fsm.sv
// rtl/m_control_fsm.sv - multicycle main control FSM; optional perf counters under M_CTRL_PERF_EN
module m_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      dec_i,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ExtZero,
  output logic [2:0]       ALUOp,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MRD = 4'd3,
    S_MWR = 4'd4,  S_WBM = 4'd5,  S_EXR = 4'd6,  S_EXS = 4'd7,
    S_WBR = 4'd8,  S_EXI = 4'd9,  S_WBI = 4'd10, S_BR  = 4'd11,
    S_JMP = 4'd12, S_JR  = 4'd13
  } state_t;

  state_t state_q, state_d;

  // Decoder one-hot lines, named for readability
  logic d_rtype, d_shift, d_branch, d_bne, d_j, d_jal, d_jr, d_jalr;
  logic d_lw, d_sw, d_addi, d_slti, d_andi, d_ori, d_xori, d_lui;
  assign {d_lui, d_xori, d_ori, d_andi, d_slti, d_addi, d_sw, d_lw,
          d_jalr, d_jr, d_jal, d_j, d_bne, d_branch, d_shift, d_rtype} = dec_i;

  logic d_imm;
  assign d_imm = d_addi | d_slti | d_andi | d_ori | d_xori | d_lui;

  // State register; reset can abort an in-flight memory access at any time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // Next state and per-state strobes; everything forced low while reset is held
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ExtZero     = 1'b0;
    ALUOp       = 3'b000;
    illegal     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = 2'b01;
            state_d = S_ID;
          end
        end
        S_ID: begin
          ALUSrcB = 2'b11;
          if (d_lw | d_sw)          state_d = S_MA;
          else if (d_rtype)         state_d = S_EXR;
          else if (d_shift)         state_d = S_EXS;
          else if (d_imm)           state_d = S_EXI;
          else if (d_branch | d_bne) state_d = S_BR;
          else if (d_j | d_jal)     state_d = S_JMP;
          else if (d_jr | d_jalr)   state_d = S_JR;
          else begin
            illegal = 1'b1;
            state_d = S_IF;
          end
        end
        S_MA: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          state_d = d_lw ? S_MRD : S_MWR;
        end
        S_MRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) state_d = S_WBM;
        end
        S_MWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) state_d = S_IF;
        end
        S_WBM: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
          state_d  = S_IF;
        end
        S_EXR: begin
          ALUSrcA = 2'b01;
          ALUOp   = 3'b010;
          state_d = S_WBR;
        end
        S_EXS: begin
          ALUSrcA = 2'b10;
          ALUOp   = 3'b010;
          state_d = S_WBR;
        end
        S_WBR: begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
          state_d  = S_IF;
        end
        S_EXI: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          ExtZero = d_andi | d_ori | d_xori;
          if (d_addi)      ALUOp = 3'b000;
          else if (d_slti) ALUOp = 3'b011;
          else if (d_andi) ALUOp = 3'b100;
          else if (d_ori)  ALUOp = 3'b101;
          else if (d_xori) ALUOp = 3'b110;
          else if (d_lui)  ALUOp = 3'b111;
          state_d = S_WBI;
        end
        S_WBI: begin
          RegWrite = 1'b1;
          state_d  = S_IF;
        end
        S_BR: begin
          ALUSrcA     = 2'b01;
          ALUOp       = 3'b001;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          BranchNe    = d_bne;
          state_d     = S_IF;
        end
        S_JMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          if (d_jal) begin
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
          state_d = S_IF;
        end
        S_JR: begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
          if (d_jalr) begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
            MemtoReg = 2'b10;
          end
          state_d = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

`ifdef M_CTRL_PERF_EN
  logic retire;
  assign retire = ((state_q == S_MWR) && mem_ready) ||
                  (state_q == S_WBM) || (state_q == S_WBR) || (state_q == S_WBI) ||
                  (state_q == S_BR)  || (state_q == S_JMP) || (state_q == S_JR);

  logic [CNT_W-1:0] cycle_q, instr_q;

  // Free-running cycle counter and retired-instruction counter, both wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (retire) instr_q <= instr_q + 1'b1;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule
